port_trace_uart: RTL and testbench

//  Debug trace stage directly downstream of the MCU51 top. Watches the four GPIO ports P0..P3 and

---
 rtl/port_trace_uart_pkg.sv | 45 ++++
 rtl/port_trace_uart_tx.sv | 89 ++++++++
 rtl/port_trace_uart.sv | 118 +++++++++++
 tb/tb_port_trace_uart.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/port_trace_uart_pkg.sv
// Shared types and constants for the port trace UART stage.
package port_trace_uart_pkg;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned REC_W          = 32;

  // Snapshot sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } seq_state_t;

  // UART serializer states
  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

  // One port snapshot, P3 in the top byte
  typedef struct packed {
    logic [7:0] p3;
    logic [7:0] p2;
    logic [7:0] p1;
    logic [7:0] p0;
  } rec_t;

  // Byte of a frame: 0 = sync header, 1..4 = P0..P3
  function automatic logic [7:0] rec_byte(input rec_t r, input logic [7:0] hdr,
                                          input logic [2:0] idx);
    logic [7:0] b;
    b = hdr;
    case (idx)
      3'd1:    b = r.p0;
      3'd2:    b = r.p1;
      3'd3:    b = r.p2;
      3'd4:    b = r.p3;
      default: b = hdr;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/port_trace_uart_tx.sv
// 8N1 UART transmitter, LSB first; one byte per tx_valid accepted in idle.
module uart_tx_8n1
  import port_trace_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       txd,
  output logic       tx_active
);

  localparam int unsigned CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_end;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign tx_ready  = (state == U_IDLE);
  assign tx_active = (state != U_IDLE);
  // Last cycle of the stop bit, so the next byte can start on the following edge
  assign tx_done   = (state == U_STOP) && baud_end;

  // Serializer: start, 8 data, stop; each bit held for CLKS_PER_BIT cycles
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= U_IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        U_IDLE: begin
          baud_cnt <= '0;
          if (tx_valid) begin
            shreg <= tx_data;
            txd   <= 1'b0;
            state <= U_START;
          end
        end
        U_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            txd      <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= '0;
            state    <= U_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        U_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= U_STOP;
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        U_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= U_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/port_trace_uart.sv
// Port trace stage: snapshots P0..P3 on change and streams each as a 5-byte UART frame.
module port_trace_uart
  import port_trace_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] P0,
  input  logic [7:0] P1,
  input  logic [7:0] P2,
  input  logic [7:0] P3,
  output logic       txd,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  rec_t           mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [REC_W-1:0] cur_bits;
  rec_t           cur, prev, rec_q;
  logic           primed;
  seq_state_t     state;
  logic [2:0]     byte_idx;
  logic           fifo_empty, fifo_full, push_req, push_ok, pop;
  logic           tx_valid, tx_ready, tx_done, tx_active;
  logic [7:0]     tx_data;

  assign cur_bits   = {P3, P2, P1, P0};
  assign cur        = rec_t'(cur_bits);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign push_req   = en && (!primed || (cur != prev));
  // A pop on the same edge frees the slot the push needs
  assign push_ok    = push_req && (!fifo_full || pop);
  assign tx_valid   = (state == S_SEND);
  assign tx_data    = rec_byte(rec_q, HEADER, byte_idx);
  assign busy       = (state != S_IDLE) || !fifo_empty || tx_active;

  // Change capture, FIFO pointers and drop accounting
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      prev     <= '0;
      primed   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (en) begin
        prev   <= cur;
        primed <= 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Snapshot storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= cur;
  end

  // Frame sequencer: pop a snapshot, hand header then P0..P3 to the serializer
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      rec_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            rec_q    <= mem[rd_ptr[AW-1:0]];
            byte_idx <= '0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            byte_idx <= byte_idx + 3'd1;
            state    <= (byte_idx == 3'd4) ? S_IDLE : S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .CLK      (CLK),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .txd      (txd),
    .tx_active(tx_active)
  );

endmodule

// File: tb/tb_port_trace_uart.sv
// Directed bench for port_trace_uart with a txd frame decoder.
module tb_port_trace_uart;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 2;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] p0, p1, p2, p3;
  logic       txd, busy, overflow;
  logic [7:0] drop_cnt;

  int         n_assert;
  int         n_fail;
  int         frame_err;
  logic [7:0] rx_q [$];

  port_trace_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .HEADER      (8'hA5)
  ) dut (
    .CLK     (clk),
    .reset   (reset),
    .en      (en),
    .P0      (p0),
    .P1      (p1),
    .P2      (p2),
    .P3      (p3),
    .txd     (txd),
    .busy    (busy),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART decoder: counts negedges from start detection, samples mid-bit
  int         mon_cnt;
  logic       mon_busy;
  logic [7:0] mon_sh;

  initial begin
    mon_cnt   = 0;
    mon_busy  = 1'b0;
    mon_sh    = '0;
    frame_err = 0;
  end

  always @(negedge clk) begin
    if (reset) begin
      mon_busy <= 1'b0;
    end else if (!mon_busy) begin
      if (txd === 1'b0) begin
        mon_busy <= 1'b1;
        mon_cnt  <= 1;
      end
    end else begin
      if (mon_cnt == 1 && txd !== 1'b0) frame_err <= frame_err + 1;
      if (mon_cnt >= 5 && mon_cnt <= 33 && (mon_cnt % 4) == 1)
        mon_sh[(mon_cnt - 5) / 4] <= txd;
      if (mon_cnt == 37) begin
        if (txd !== 1'b1) frame_err <= frame_err + 1;
        rx_q.push_back(mon_sh);
        mon_busy <= 1'b0;
      end
      mon_cnt <= mon_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_b [5];
    logic [7:0] b;
    int waited;
    exp_b  = '{8'hA5, e0, e1, e2, e3};
    waited = 0;
    while (rx_q.size() < 5 && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " frame available"}, 32'(rx_q.size() >= 5), 32'd1);
    if (rx_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        b = rx_q.pop_front();
        check($sformatf("%s byte%0d", tag, i), 32'(b), 32'(exp_b[i]));
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    while (busy !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    en    = 1'b1;
    p0 = 8'h00; p1 = 8'h00; p2 = 8'h00; p3 = 8'h00;

    // 1: reset state, first snapshot latency, single frame of zeros
    tick(2);
    check("rst txd", 32'(txd), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst drop_cnt", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    tick(1);
    check("t1 busy after push", 32'(busy), 32'd1);
    check("t1 txd edge N", 32'(txd), 32'd1);
    tick(1);
    check("t1 txd edge N+1", 32'(txd), 32'd1);
    tick(1);
    check("t1 start bit edge N+2", 32'(txd), 32'd0);
    expect_frame("t1", 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle("t1");
    check("t1 txd idle", 32'(txd), 32'd1);
    tick(300);
    check("t1 no extra frame", 32'(rx_q.size()), 32'd0);
    check("t1 still idle", 32'(busy), 32'd0);

    // 2: one-cycle pulse on P1 gives two frames
    p1 = 8'h3C;
    tick(1);
    p1 = 8'h00;
    expect_frame("t2a", 8'h00, 8'h3C, 8'h00, 8'h00);
    expect_frame("t2b", 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle("t2");

    // 4: FIFO full, change lands on the pop edge and is kept
    p0 = 8'h11;
    tick(1);
    p0 = 8'h22;
    tick(1);
    p0 = 8'h33;
    tick(205);
    p0 = 8'h44;
    tick(1);
    check("t4 overflow", 32'(overflow), 32'd0);
    check("t4 drop_cnt", 32'(drop_cnt), 32'd0);
    expect_frame("t4a", 8'h11, 8'h00, 8'h00, 8'h00);
    expect_frame("t4b", 8'h22, 8'h00, 8'h00, 8'h00);
    expect_frame("t4c", 8'h33, 8'h00, 8'h00, 8'h00);
    expect_frame("t4d", 8'h44, 8'h00, 8'h00, 8'h00);
    wait_idle("t4");
    check("t4 overflow after", 32'(overflow), 32'd0);

    // 3: ten back-to-back changes overflow a 2-entry FIFO
    for (int i = 1; i <= 10; i++) begin
      p0 = 8'(i);
      tick(1);
    end
    check("t3 overflow", 32'(overflow), 32'd1);
    check("t3 drop_cnt", 32'(drop_cnt), 32'd7);
    expect_frame("t3a", 8'h01, 8'h00, 8'h00, 8'h00);
    expect_frame("t3b", 8'h02, 8'h00, 8'h00, 8'h00);
    expect_frame("t3c", 8'h03, 8'h00, 8'h00, 8'h00);
    wait_idle("t3");
    check("t3 no extra frame", 32'(rx_q.size()), 32'd0);

    // 3b: drop counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      p0 = p0 + 8'd1;
      tick(1);
    end
    check("t3 drop_cnt saturated", 32'(drop_cnt), 32'd255);
    wait_idle("t3 sat");
    tick(2);
    rx_q.delete();

    // 5: reset during byte 2 of a frame aborts it and clears counters
    p0 = 8'h00; p1 = 8'h00; p2 = 8'h55; p3 = 8'h00;
    tick(1);
    tick(85);
    check("t5 overflow before", 32'(overflow), 32'd1);
    check("t5 txd in start bit", 32'(txd), 32'd0);
    reset = 1'b1;
    tick(1);
    check("t5 txd after reset", 32'(txd), 32'd1);
    check("t5 busy after reset", 32'(busy), 32'd0);
    check("t5 overflow cleared", 32'(overflow), 32'd0);
    check("t5 drop_cnt cleared", 32'(drop_cnt), 32'd0);
    check("t5 bytes before abort", 32'(rx_q.size()), 32'd2);
    rx_q.delete();
    reset = 1'b0;
    expect_frame("t5 fresh", 8'h00, 8'h00, 8'h55, 8'h00);
    wait_idle("t5");

    // 6: en=0 drains queued frames and ignores port activity
    p3 = 8'h77;
    tick(1);
    p3 = 8'h88;
    tick(1);
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      p0 = 8'($urandom);
      p1 = 8'($urandom);
      p2 = 8'($urandom);
      p3 = 8'($urandom);
      tick(1);
    end
    p0 = 8'h00; p1 = 8'h00; p2 = 8'h55; p3 = 8'h88;
    en = 1'b1;
    expect_frame("t6a", 8'h00, 8'h00, 8'h55, 8'h77);
    expect_frame("t6b", 8'h00, 8'h00, 8'h55, 8'h88);
    wait_idle("t6");
    tick(300);
    check("t6 no frame after re-enable", 32'(rx_q.size()), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 overflow", 32'(overflow), 32'd0);
    check("framing errors", 32'(frame_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
